// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the pipeline stall/flush sequencer:
//   - PC select codes (sequential / exception vector / EPC)
//   - default exception entry address
//   - mult/div busy-counter width
//   - sequencer state encoding
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0]  pc_sel_seq  = 2'd0;
    localparam logic [1:0]  pc_sel_exc  = 2'd1;
    localparam logic [1:0]  pc_sel_epc  = 2'd2;

    localparam logic [31:0] exc_vector  = 32'h0000_4180;

    localparam int          md_cnt_size = 5;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } hz_state_e;

endpackage : pipe_hazard_ctrl_pkg

// File: rtl/pipe_hazard_ctrl_md_busy_counter.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_md_busy_counter
// Tracks how many cycles the multi-cycle mult/div unit still needs.
// Ports:
//   Clock      in   pipeline clock
//   Reset      in   asynchronous active-low reset
//   Load_i     in   mult/div launch request from E
//   Type_i     in   0 = mult/multu, 1 = div/divu
//   Cancel_i   in   flush this cycle; the launching instruction is cancelled
//   Busy_o     out  result pending (counter non-zero), registered
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl_md_busy_counter
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Load_i,
    input  logic Type_i,
    input  logic Cancel_i,
    output logic Busy_o
);

    localparam logic [md_cnt_size-1:0] MULT_LD = md_cnt_size'(MULT_CYCLES);
    localparam logic [md_cnt_size-1:0] DIV_LD  = md_cnt_size'(DIV_CYCLES);

    logic [md_cnt_size-1:0] cnt_q, cnt_d;
    logic                   busy;

    assign busy = (cnt_q != '0);

    // A launch while already busy cannot legally happen (the D-stage stall
    // holds it back); if it does, the running count is kept.
    always_comb begin
        cnt_d = cnt_q;
        if (Load_i && !Cancel_i && !busy) begin
            cnt_d = Type_i ? DIV_LD : MULT_LD;
        end else if (busy) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Busy_o = busy;

endmodule : pipe_hazard_ctrl_md_busy_counter

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush sequencer for the five-stage pipeline. Drives the
// enables and synchronous clears of the FD/DE/EM/MW pipeline registers and
// the PC update from hazard requests, mult/div occupancy and M-stage
// exception/ERET events.
//
// Build option:
//   PIPE_MD_STALL_EN  defined   -> mult/div busy counter present, D_MdUse
//                                  stalls while a result is pending
//                     undefined -> no counter, Md_Busy = 0, stall = D_Stall
//
// Ports:
//   Clock, Reset           pipeline clock, asynchronous active-low reset
//   D_Stall                data-hazard stall request from D
//   D_MdUse                instruction in D uses mult/div or HI/LO
//   E_MdStart, E_MdType    mult/div launch in E and its kind (1 = div)
//   M_ExcReq, M_Eret       exception taken / ERET on the M instruction
//   M_Epc                  EPC from CP0
//   Pc_En, Pc_Sel          PC write enable and source (0 seq, 1 vec, 2 EPC)
//   Pc_Target              redirect address for Pc_Sel = 1/2, else 0
//   {FD,DE,EM,MW}_En/_Clr  pipeline register enables / sync clears
//   Md_Busy                mult/div result pending (registered)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int          MULT_CYCLES = 5,
    parameter int          DIV_CYCLES  = 10,
    parameter logic [31:0] EXC_VECTOR  = exc_vector
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        D_Stall,
    input  logic        D_MdUse,
    input  logic        E_MdStart,
    input  logic        E_MdType,
    input  logic        M_ExcReq,
    input  logic        M_Eret,
    input  logic [31:0] M_Epc,
    output logic        Pc_En,
    output logic [1:0]  Pc_Sel,
    output logic [31:0] Pc_Target,
    output logic        FD_En,
    output logic        DE_En,
    output logic        EM_En,
    output logic        MW_En,
    output logic        FD_Clr,
    output logic        DE_Clr,
    output logic        EM_Clr,
    output logic        MW_Clr,
    output logic        Md_Busy
);

    hz_state_e state_q, state_d;
    logic      flush;
    logic      exc_flush;
    logic      stall;
    logic      md_busy;

    // -----------------------------------------------------------------------
    // Sequencer: one FLUSH cycle after every flush. Events seen in FLUSH are
    // ignored so a level-held interrupt cannot re-trigger back to back.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        flush     = 1'b0;
        exc_flush = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (M_ExcReq || M_Eret) begin
                    flush     = 1'b1;
                    exc_flush = M_ExcReq;
                    state_d   = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Mult/div occupancy
    // -----------------------------------------------------------------------
`ifdef PIPE_MD_STALL_EN
    // A launch coincident with a flush belongs to a cancelled instruction.
    pipe_hazard_ctrl_md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_counter (
        .Clock    (Clock),
        .Reset    (Reset),
        .Load_i   (E_MdStart),
        .Type_i   (E_MdType),
        .Cancel_i (flush),
        .Busy_o   (md_busy)
    );

    // The launching instruction itself already blocks its HI/LO consumer.
    assign stall = D_Stall | (D_MdUse & (md_busy | E_MdStart));
`else
    logic                   unused_md_inputs;
    logic [md_cnt_size-1:0] unused_md_cfg;

    assign unused_md_inputs = D_MdUse ^ E_MdStart ^ E_MdType;
    assign unused_md_cfg    = md_cnt_size'(MULT_CYCLES) ^ md_cnt_size'(DIV_CYCLES);
    assign md_busy          = 1'b0;
    assign stall            = D_Stall;
`endif

    assign Md_Busy = md_busy;

    // -----------------------------------------------------------------------
    // Register controls. Reset forces every stage into clear with enables
    // off; flush outranks any stall.
    // -----------------------------------------------------------------------
    always_comb begin
        Pc_En     = 1'b1;
        Pc_Sel    = pc_sel_seq;
        Pc_Target = '0;
        FD_En     = 1'b1;
        DE_En     = 1'b1;
        EM_En     = 1'b1;
        MW_En     = 1'b1;
        FD_Clr    = 1'b0;
        DE_Clr    = 1'b0;
        EM_Clr    = 1'b0;
        MW_Clr    = 1'b0;

        if (!Reset) begin
            Pc_En  = 1'b0;
            FD_En  = 1'b0;
            DE_En  = 1'b0;
            EM_En  = 1'b0;
            MW_En  = 1'b0;
            FD_Clr = 1'b1;
            DE_Clr = 1'b1;
            EM_Clr = 1'b1;
            MW_Clr = 1'b1;
        end else if (flush) begin
            FD_Clr = 1'b1;
            DE_Clr = 1'b1;
            EM_Clr = 1'b1;
            // ERET in M completes, so MW keeps it; an exception kills it.
            MW_Clr = exc_flush;
            if (exc_flush) begin
                Pc_Sel    = pc_sel_exc;
                Pc_Target = EXC_VECTOR;
            end else begin
                Pc_Sel    = pc_sel_epc;
                Pc_Target = M_Epc;
            end
        end else if (stall) begin
            Pc_En  = 1'b0;
            FD_En  = 1'b0;
            DE_Clr = 1'b1;
        end
    end

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

`ifdef PIPE_MD_STALL_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic        Clock;
    logic        Reset;
    logic        D_Stall, D_MdUse, E_MdStart, E_MdType, M_ExcReq, M_Eret;
    logic [31:0] M_Epc;
    logic        Pc_En;
    logic [1:0]  Pc_Sel;
    logic [31:0] Pc_Target;
    logic        FD_En, DE_En, EM_En, MW_En;
    logic        FD_Clr, DE_Clr, EM_Clr, MW_Clr;
    logic        Md_Busy;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .D_Stall   (D_Stall),
        .D_MdUse   (D_MdUse),
        .E_MdStart (E_MdStart),
        .E_MdType  (E_MdType),
        .M_ExcReq  (M_ExcReq),
        .M_Eret    (M_Eret),
        .M_Epc     (M_Epc),
        .Pc_En     (Pc_En),
        .Pc_Sel    (Pc_Sel),
        .Pc_Target (Pc_Target),
        .FD_En     (FD_En),
        .DE_En     (DE_En),
        .EM_En     (EM_En),
        .MW_En     (MW_En),
        .FD_Clr    (FD_Clr),
        .DE_Clr    (DE_Clr),
        .EM_Clr    (EM_Clr),
        .MW_Clr    (MW_Clr),
        .Md_Busy   (Md_Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // {Pc_En, Pc_Sel, Pc_Target, {FD,DE,EM,MW}_En, {FD,DE,EM,MW}_Clr, Md_Busy}
    typedef logic [43:0] obs_t;

    typedef struct {
        string       name;
        logic        rst_n, d_stall, d_mduse, e_start, e_type, exc, eret;
        logic [31:0] epc;
        obs_t        exp;
    } vec_t;

    vec_t vecs[$];

    function automatic obs_t mk(logic pe, logic [1:0] ps, logic [31:0] tgt,
                                logic [3:0] en, logic [3:0] clr, logic busy);
        return {pe, ps, tgt, en, clr, busy};
    endfunction

    function automatic obs_t o_rst();
        return mk(1'b0, 2'd0, 32'h0, 4'b0000, 4'b1111, 1'b0);
    endfunction
    function automatic obs_t o_norm(logic b);
        return mk(1'b1, 2'd0, 32'h0, 4'b1111, 4'b0000, b);
    endfunction
    function automatic obs_t o_stall(logic b);
        return mk(1'b0, 2'd0, 32'h0, 4'b0111, 4'b0100, b);
    endfunction
    function automatic obs_t o_exc(logic b);
        return mk(1'b1, 2'd1, 32'h0000_4180, 4'b1111, 4'b1111, b);
    endfunction
    function automatic obs_t o_eret(logic [31:0] epc, logic b);
        return mk(1'b1, 2'd2, epc, 4'b1111, 4'b1110, b);
    endfunction
    // mult/div-use stall only exists when the counter is built in
    function automatic obs_t o_md(logic b);
        return MD ? o_stall(b) : o_norm(1'b0);
    endfunction

    task automatic add(string nm, logic r, logic ds, logic mu, logic st, logic ty,
                       logic ex, logic er, logic [31:0] epc, obs_t e);
        vec_t v;
        v.name = nm; v.rst_n = r; v.d_stall = ds; v.d_mduse = mu;
        v.e_start = st; v.e_type = ty; v.exc = ex; v.eret = er;
        v.epc = epc; v.exp = e;
        vecs.push_back(v);
    endtask

    function automatic obs_t sample();
        return {Pc_En, Pc_Sel, Pc_Target, FD_En, DE_En, EM_En, MW_En,
                FD_Clr, DE_Clr, EM_Clr, MW_Clr, Md_Busy};
    endfunction

    task automatic check(string nm, obs_t exp);
        obs_t act;
        act = sample();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        Reset     = v.rst_n;
        D_Stall   = v.d_stall;
        D_MdUse   = v.d_mduse;
        E_MdStart = v.e_start;
        E_MdType  = v.e_type;
        M_ExcReq  = v.exc;
        M_Eret    = v.eret;
        M_Epc     = v.epc;
    endtask

    initial begin
        Reset = 1'b0; D_Stall = 0; D_MdUse = 0; E_MdStart = 0; E_MdType = 0;
        M_ExcReq = 0; M_Eret = 0; M_Epc = 32'h0;

        //   name           rst ds mu st ty ex er epc           expected
        add("reset0",       0, 0, 0, 0, 0, 0, 0, 32'h0,       o_rst());
        add("reset1",       0, 0, 0, 0, 0, 0, 0, 32'h0,       o_rst());
        add("run_idle",     1, 0, 0, 0, 0, 0, 0, 32'h0,       o_norm(0));
        add("d_stall",      1, 1, 0, 0, 0, 0, 0, 32'h0,       o_stall(0));
        add("after_stall",  1, 0, 0, 0, 0, 0, 0, 32'h0,       o_norm(0));
        // mult launch with dependent instruction waiting in D
        add("mult_t0",      1, 0, 1, 1, 0, 0, 0, 32'h0,       o_md(0));
        for (int i = 1; i <= 5; i++)
            add($sformatf("mult_t%0d", i), 1, 0, 1, 0, 0, 0, 0, 32'h0, o_md(MD));
        add("mult_t6",      1, 0, 1, 0, 0, 0, 0, 32'h0,       o_norm(0));
        // div launch
        add("div_t0",       1, 0, 1, 1, 1, 0, 0, 32'h0,       o_md(0));
        for (int i = 1; i <= 10; i++)
            add($sformatf("div_t%0d", i), 1, 0, 1, 0, 0, 0, 0, 32'h0, o_md(MD));
        add("div_t11",      1, 0, 1, 0, 0, 0, 0, 32'h0,       o_norm(0));
        // exception beats stall and cancels the coincident launch
        add("exc_all",      1, 1, 0, 1, 0, 1, 0, 32'h0,       o_exc(0));
        add("exc_held",     1, 0, 0, 0, 0, 1, 0, 32'h0,       o_norm(0));
        add("exc_gone",     1, 0, 0, 0, 0, 0, 0, 32'h0,       o_norm(0));
        add("eret",         1, 0, 0, 0, 0, 0, 1, 32'h3008,    o_eret(32'h3008, 0));
        add("eret_held",    1, 0, 0, 0, 0, 0, 1, 32'h3008,    o_norm(0));
        add("exc_and_eret", 1, 0, 0, 0, 0, 1, 1, 32'h3008,    o_exc(0));
        add("flush_idle",   1, 0, 0, 0, 0, 0, 0, 32'h0,       o_norm(0));
        add("run_stall",    1, 1, 0, 0, 0, 0, 0, 32'h0,       o_stall(0));
        // mult keeps running through a flush, then reset lands mid-mult
        add("mult2_t0",     1, 0, 0, 1, 0, 0, 0, 32'h0,       o_norm(0));
        add("mult2_t1",     1, 0, 0, 0, 0, 0, 0, 32'h0,       o_norm(MD));
        add("mult2_eret",   1, 0, 0, 0, 0, 0, 1, 32'h0000_1234, o_eret(32'h0000_1234, MD));
        add("mult2_t3",     1, 0, 0, 0, 0, 0, 0, 32'h0,       o_norm(MD));
        add("reset_mid",    0, 0, 0, 0, 0, 0, 0, 32'h0,       o_rst());
        add("reset_hold",   0, 0, 0, 0, 0, 0, 0, 32'h0,       o_rst());
        add("post_reset",   1, 0, 0, 0, 0, 0, 0, 32'h0,       o_norm(0));

        // apply just after each rising edge, observe on the falling edge
        foreach (vecs[i]) begin
            @(posedge Clock);
            #1;
            drive(vecs[i]);
            @(negedge Clock);
            check(vecs[i].name, vecs[i].exp);
        end

        // hand-written: reset asserted in the middle of a div, not on an edge
        @(posedge Clock); #1;
        E_MdStart = 1'b1; E_MdType = 1'b1; D_MdUse = 1'b0;
        @(posedge Clock); #1;
        E_MdStart = 1'b0;
        @(posedge Clock); #1;
        @(negedge Clock);
        check("div_busy_mid", o_norm(MD));
        #2;
        Reset = 1'b0;
        #1;
        check("async_reset", o_rst());
        @(posedge Clock); #1;
        Reset = 1'b1;
        @(negedge Clock);
        check("release", o_norm(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule : tb_pipe_hazard_ctrl
